// File: rtl/clk_rst_seq_pkg.sv
// Shared types and default sizes for the clock-enable / reset sequencer.
package clk_rst_seq_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_DIV_W    = 8;
  localparam int DEF_CYC_W    = 32;
  localparam int DEF_RST_HOLD = 4;

endpackage

// File: rtl/clk_rst_seq_div_ch.sv
// One clock-enable divider channel: pulses once every max(div_i,1) enabled cycles.
module clk_div_ch
  import clk_rst_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             en_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] d_m1;

  // The >= compare lets a ratio lowered mid-count fire at once instead of wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    d_m1  = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    en_o  = run_i && (cnt_q >= d_m1);
    if (run_i) begin
      cnt_d = en_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer with N_CH divided clock-enable channels and an optional run-cycle
// budget; the counter and DONE state exist only when CLK_RST_SEQ_CNT_EN is defined.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int RST_HOLD   = DEF_RST_HOLD,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int SIM_CYCLES = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
  output logic                  rst_n_o,
  output logic [N_CH-1:0]       clk_en_o,
  output logic [CYC_W-1:0]      cycle_cnt_o,
  output logic                  done_o
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              rst_n_q;
  logic              budget_hit;
  logic              ch_run;

`ifdef CLK_RST_SEQ_CNT_EN
  logic [CYC_W-1:0] cyc_q, cyc_d;

  // Counting stops outside RUN, so the value saturates at SIM_CYCLES in DONE.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == RUN) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign budget_hit  = (SIM_CYCLES != 0) && (cyc_q == CYC_W'(SIM_CYCLES - 1));
  assign cycle_cnt_o = cyc_q;
  assign done_o      = (state_q == DONE);
`else
  assign budget_hit  = 1'b0;
  assign cycle_cnt_o = '0;
  assign done_o      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      RESET: begin
        if (sync_q[1]) begin
          hold_cnt_d = '0;
          state_d    = (RST_HOLD == 0) ? RUN : HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (budget_hit) begin
          state_d = DONE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = RESET;
    endcase
  end

  // rst_n_o is registered from the next state so it rises on the same edge that enters RUN.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RESET;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], 1'b1};
      hold_cnt_q <= hold_cnt_d;
      rst_n_q    <= (state_d == RUN) || (state_d == DONE);
    end
  end

  assign rst_n_o = rst_n_q;
  assign ch_run  = (state_q == RUN) && en_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .run_i (ch_run),
      .div_i (div_i[c*DIV_W +: DIV_W]),
      .en_o  (clk_en_o[c])
    );
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Parametrised clock-enable and reset sequencer for frontend testbenches and simulation tops. It runs from one free-running base clock and produces a synchronised, stretched active-low reset plus N_CH independently divided clock-enable pulse trains. It also counts run cycles and flags end-of-simulation after a programmable cycle budget, so benches stop hard-coding periods, reset delays and repeat counts.

## Interface
- N_CH, 2: number of clock-enable channels (≥1)
- DIV_W, 8: width of each channel's divide ratio
- RST_HOLD, 4: cycles rst_n_o stays low after the synchronised release (≥0)
- CYC_W, 32: width of run-cycle counter
- SIM_CYCLES, 25: run-cycle budget before done_o; 0 = unlimited

- clk_i  in  1  base clock
- rst_ni  in  1  asynchronous, active-low reset
- en_i  in  1  global pulse enable; low pauses channel counters
- div_i  in  N_CH×DIV_W  per-channel divide ratio d (0 treated as 1)
- rst_n_o  out  1  synchronised, stretched reset for the DUT
- clk_en_o  out  N_CH  one-cycle enable pulse per channel
- cycle_cnt_o  out  CYC_W  run cycles elapsed
- done_o  out  1  sticky end-of-simulation flag

## Operation
- FSM states: RESET, HOLD, RUN, DONE. RESET on rst_ni low, asynchronously.
- Reset values: rst_n_o=0, clk_en_o=0, cycle_cnt_o=0, done_o=0, all channel counters 0, sync flops 0.
- Release path: rst_ni goes through a 2-flop synchroniser. RESET→HOLD when the synchroniser output is 1. The hold counter counts RST_HOLD cycles, then HOLD→RUN. With RST_HOLD=0, HOLD lasts 0 cycles and RESET→RUN directly.
- rst_n_o = registered (state==RUN || state==DONE).
- Per channel in RUN with en_i=1, d_eff = max(d,1):
  - clk_en_o[c] = (cnt==d_eff-1) or (cnt ≥ d_eff).
  - The counter resets to 0 on a pulse and otherwise increments.
  - With en_i=0, counters hold and clk_en_o=0.
- div_i change mid-count: the new ratio takes effect immediately. If cnt ≥ new d_eff-1, the channel pulses that cycle and restarts at 0. No lost or double pulses beyond that.
- cycle_cnt_o increments every RUN cycle regardless of en_i.
- If SIM_CYCLES≠0 and cycle_cnt_o==SIM_CYCLES-1 in RUN: next state DONE, done_o=1, cycle_cnt_o=SIM_CYCLES. It then saturates, clk_en_o is forced to 0, and rst_n_o stays 1.
- DONE exits only via rst_ni.
- Asserting rst_ni mid-RUN or mid-DONE asynchronously returns every output to its reset value, including done_o. The full release sequence repeats.

## Timing
- Edge 1 is the first rising edge sampling rst_ni=1. The synchroniser output is 1 after edge 2. rst_n_o rises on edge 3+RST_HOLD.
- A rst_ni pulse shorter than one cycle still forces reset: the reset is asynchronous and glitch-level.
- Run cycle k=0 is the first cycle with rst_n_o=1. Channel c with constant d pulses at k = d-1, 2d-1, …; with d=1 it pulses every cycle.
- clk_en_o is combinational from state, counter, div_i and en_i: zero latency from en_i/div_i.
- done_o rises on the edge ending run cycle SIM_CYCLES-1. clk_en_o is 0 from run cycle SIM_CYCLES onward.

## Configuration
- CLK_RST_SEQ_CNT_EN defined: the cycle counter, the SIM_CYCLES budget and the DONE state are built as described.
- CLK_RST_SEQ_CNT_EN undefined: no counter and no DONE state. cycle_cnt_o is tied to 0 and done_o to 0. RUN persists until rst_ni; SIM_CYCLES is ignored.

## Structure
- clk_rst_seq_pkg holds:
  - the state enum type (RESET, HOLD, RUN, DONE)
  - default localparams for DIV_W, CYC_W and RST_HOLD
- Sub-module clk_div_ch: one divider channel, generated N_CH times. Ports: clk_i, rst_ni, run_i, div_i, en_o.

## Test plan
- RST_HOLD=4, rst_ni released before edge 1 → rst_n_o low through edge 6, high after edge 7; all other outputs 0 until then.
- div_i={1,4}, en_i=1 → ch0 pulses every run cycle; ch1 pulses at k=3,7,11.
- ch1 cnt=5 with d=8, div_i changed to 3 → pulse that cycle, then at k+3, k+6.
- en_i low for run cycles 2–5 with d=4 → no pulses in 2–5; ch counter frozen; cycle_cnt_o still advances; next pulse delayed by 4 cycles.
- SIM_CYCLES=25 → done_o rises after run cycle 24; cycle_cnt_o saturates at 25; clk_en_o stays 0 afterwards.
- rst_ni asserted mid-DONE for 3 ns → immediate rst_n_o=0, done_o=0, cycle_cnt_o=0; the full release sequence repeats. Also run with the macro undefined: done_o and cycle_cnt_o stay 0.
